systolic_host_seq: RTL and testbench

- Parametrised host-side wrapper and run sequencer for an N x N weight-stationary systolic array (array instantiated outside this block).
- Holds three N*N buffers behind a single-cycle host register port:
  - B: weights, loaded into the array.
  - A: input matrix, streamed into the array.
  - C: results, captured from the array.
- A start command runs a fixed FSM that sequences the array's clear and shift enables, skews A onto the left edge and captures the bottom partial sums into C.
- Successor to the fixed 8x8 manual-shift wrapper: N, width and latency are parametrised, and the run is automated.

---
 rtl/systolic_pkg.sv | 32 +++
 rtl/systolic_host_seq_if.sv | 18 +
 rtl/systolic_a_skew.sv | 37 +++
 rtl/systolic_host_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_systolic_host_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared encodings for the systolic host sequencer: host regions, CSR map,
// STATUS bit positions and the run FSM states.
package systolic_pkg;

   localparam logic [1:0] REG_B   = 2'd0;
   localparam logic [1:0] REG_A   = 2'd1;
   localparam logic [1:0] REG_C   = 2'd2;
   localparam logic [1:0] REG_CSR = 2'd3;

   localparam int unsigned CSR_CTRL   = 0;
   localparam int unsigned CSR_STATUS = 1;
   localparam int unsigned CSR_CYC_LO = 2;
   localparam int unsigned CSR_CYC_HI = 3;

   localparam int unsigned CTRL_START   = 0;
   localparam int unsigned CTRL_CLR_ERR = 2;

   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_DONE = 1;
   localparam int unsigned STAT_ERR  = 2;

   localparam int unsigned CYC_CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD_B,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/systolic_host_seq_if.sv
// Single-cycle host register port: write/read strobes, region+index address,
// registered read data with a one-cycle valid pulse.
interface systolic_host_seq_if #(
   parameter int unsigned N      = 8,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned IDX_W = $clog2(N * N);

   logic              we;
   logic              re;
   logic [IDX_W+1:0]  addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (output we, re, addr, wdata, input rdata, rvalid);
   modport slave  (input we, re, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/systolic_a_skew.sv
// Skews matrix A onto the array's left edge: lane i carries A[t-i][i] while
// that row exists, else 0. Driven with next-cycle t so the lanes are registered.
module systolic_a_skew #(
   parameter int unsigned N      = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid,
   input  logic [CNT_W-1:0]         t,
   input  logic [N*N*DATA_W-1:0]    a_flat,
   output logic [N*DATA_W-1:0]      lanes
);

   logic [N*DATA_W-1:0] lanes_nxt;
   int                  row;

   always_comb begin
      lanes_nxt = '0;
      row       = 0;
      if (valid) begin
         for (int i = 0; i < int'(N); i++) begin
            row = int'(t) - i;
            if (row >= 0 && row < int'(N)) begin
               lanes_nxt[i*DATA_W +: DATA_W] = a_flat[(row*int'(N) + i)*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lanes <= '0;
      else        lanes <= lanes_nxt;
   end

endmodule

// File: rtl/systolic_host_seq.sv
// Host-side wrapper and run sequencer for an N x N weight-stationary systolic array.
// Optional run-cycle counter at CSR 2/3 when SYS_HOST_CYCLE_CNT_EN is defined.
module systolic_host_seq
   import systolic_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LAT    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_host_seq_if.slave    host,
   output logic                  irq_done,
   output logic                  arr_data_clear,
   output logic                  arr_en_b_shift_bottom,
   output logic                  arr_en_shift_right,
   output logic                  arr_en_shift_bottom,
   output logic [N*DATA_W-1:0]   arr_a_left,
   output logic [N*DATA_W-1:0]   arr_b_top,
   input  logic [N*DATA_W-1:0]   arr_ps_bottom
);

   localparam int unsigned IDX_W      = $clog2(N * N);
   localparam int unsigned NW         = N * N;
   localparam int unsigned CNT_W      = $clog2(2 * N + LAT);
   localparam int unsigned STREAM_LEN = 2 * N - 1 + LAT;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

   logic [DATA_W-1:0]  b_mem [NW];
   logic [DATA_W-1:0]  a_mem [NW];
   logic [DATA_W-1:0]  c_mem [NW];
   logic [N*N*DATA_W-1:0] a_flat;

   logic               done, err, busy;
   logic [1:0]         region;
   logic [IDX_W-1:0]   idx;
   logic               ctrl_wr, start_req, start_ok, err_set, err_clr;
   logic [DATA_W-1:0]  rd_word;
   logic [N*DATA_W-1:0] b_top_nxt;
   logic [N-1:0]       c_wr;
   logic [IDX_W-1:0]   c_idx [N];
   int                 c_row;

   // Host command decode
   assign region    = host.addr[IDX_W+1:IDX_W];
   assign idx       = host.addr[IDX_W-1:0];
   assign busy      = (state == CLEAR) || (state == LOAD_B) || (state == STREAM);
   assign ctrl_wr   = host.we && (region == REG_CSR) && (idx == IDX_W'(CSR_CTRL));
   assign start_req = ctrl_wr && host.wdata[CTRL_START];
   assign start_ok  = start_req && !busy;
   assign err_clr   = ctrl_wr && host.wdata[CTRL_CLR_ERR];
   assign err_set   = (host.we && busy && ((region == REG_B) || (region == REG_A)))
                    || (host.we && (region == REG_C))
                    || (start_req && busy);

   // Run FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Run FSM: next state; DONE may accept a new start directly
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_ok) state_nxt = CLEAR;
         CLEAR:   state_nxt = LOAD_B;
         LOAD_B:  if (cnt == CNT_W'(N - 1)) state_nxt = STREAM;
         STREAM:  if (cnt == CNT_W'(STREAM_LEN - 1)) state_nxt = DONE;
         DONE:    state_nxt = start_ok ? CLEAR : IDLE;
         default: state_nxt = IDLE;
      endcase
      cnt_nxt = (state_nxt != state || state_nxt == IDLE) ? '0 : cnt + CNT_W'(1);
   end

   // Weight row for the next LOAD_B step, bottom row first
   always_comb begin
      b_top_nxt = '0;
      if (state_nxt == LOAD_B) begin
         for (int j = 0; j < int'(N); j++) begin
            b_top_nxt[j*DATA_W +: DATA_W] =
               b_mem[IDX_W'((int'(N) - 1 - int'(cnt_nxt)) * int'(N) + j)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_done              <= 1'b0;
         arr_data_clear        <= 1'b0;
         arr_en_b_shift_bottom <= 1'b0;
         arr_en_shift_right    <= 1'b0;
         arr_en_shift_bottom   <= 1'b0;
         arr_b_top             <= '0;
      end else begin
         irq_done              <= (state_nxt == DONE);
         arr_data_clear        <= (state_nxt == CLEAR);
         arr_en_b_shift_bottom <= (state_nxt == LOAD_B);
         arr_en_shift_right    <= (state_nxt == STREAM);
         arr_en_shift_bottom   <= (state_nxt == STREAM);
         arr_b_top             <= b_top_nxt;
      end
   end

   always_comb begin
      a_flat = '0;
      for (int k = 0; k < int'(NW); k++) a_flat[k*DATA_W +: DATA_W] = a_mem[k];
   end

   systolic_a_skew #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_a_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (state_nxt == STREAM),
      .t      (cnt_nxt),
      .a_flat (a_flat),
      .lanes  (arr_a_left)
   );

   // Column j's bottom sum for row t-j-LAT arrives in STREAM cycle t
   always_comb begin
      c_wr  = '0;
      c_idx = '{default: '0};
      c_row = 0;
      if (state == STREAM) begin
         for (int j = 0; j < int'(N); j++) begin
            c_row = int'(cnt) - j - int'(LAT);
            if (c_row >= 0 && c_row < int'(N)) begin
               c_wr[j]  = 1'b1;
               c_idx[j] = IDX_W'(c_row * int'(N) + j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NW); k++) begin
            b_mem[k] <= '0;
            a_mem[k] <= '0;
         end
      end else if (host.we && !busy) begin
         if (region == REG_B) b_mem[idx] <= host.wdata;
         if (region == REG_A) a_mem[idx] <= host.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NW); k++) c_mem[k] <= '0;
      end else begin
         for (int j = 0; j < int'(N); j++) begin
            if (c_wr[j]) c_mem[c_idx[j]] <= arr_ps_bottom[j*DATA_W +: DATA_W];
         end
      end
   end

   // Sticky status: err set wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         if (start_ok)                done <= 1'b0;
         else if (state_nxt == DONE)  done <= 1'b1;
         if (err_set)                 err  <= 1'b1;
         else if (err_clr)            err  <= 1'b0;
      end
   end

`ifdef SYS_HOST_CYCLE_CNT_EN
   localparam int unsigned CYC_EXT_W = 2 * DATA_W;
   logic [CYC_CNT_W-1:0] cyc_cnt;
   logic [CYC_EXT_W-1:0] cyc_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cyc_cnt <= '0;
      else if (start_ok)       cyc_cnt <= '0;
      else if (state != IDLE)  cyc_cnt <= cyc_cnt + CYC_CNT_W'(1);
   end

   assign cyc_ext = CYC_EXT_W'(cyc_cnt);
`endif

   // Read mux sees pre-write contents, so a same-cycle write never bypasses
   always_comb begin
      rd_word = '0;
      unique case (region)
         REG_B: rd_word = b_mem[idx];
         REG_A: rd_word = a_mem[idx];
         REG_C: rd_word = c_mem[idx];
         default: begin
            if (idx == IDX_W'(CSR_STATUS)) begin
               rd_word[STAT_BUSY] = busy;
               rd_word[STAT_DONE] = done;
               rd_word[STAT_ERR]  = err;
            end
`ifdef SYS_HOST_CYCLE_CNT_EN
            else if (idx == IDX_W'(CSR_CYC_LO)) rd_word = cyc_ext[DATA_W-1:0];
            else if (idx == IDX_W'(CSR_CYC_HI)) rd_word = cyc_ext[2*DATA_W-1:DATA_W];
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host.rdata  <= '0;
         host.rvalid <= 1'b0;
      end else begin
         host.rvalid <= host.re;
         if (host.re) host.rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_systolic_host_seq.sv
// Directed bench for systolic_host_seq (N=4, LAT=4) with a behavioural
// weight-stationary array model driving the bottom partial sums.
module tb_systolic_host_seq;
   import systolic_pkg::*;

   localparam int unsigned N      = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LAT    = 4;
   localparam int unsigned IDX_W  = $clog2(N * N);
   localparam int unsigned AW     = IDX_W + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                irq_done, arr_data_clear, arr_en_b_shift_bottom;
   logic                arr_en_shift_right, arr_en_shift_bottom;
   logic [N*DATA_W-1:0] arr_a_left, arr_b_top;
   logic [N*DATA_W-1:0] arr_ps_bottom = '0;

   systolic_host_seq_if #(.N(N), .DATA_W(DATA_W)) host_bus ();

   systolic_host_seq #(.N(N), .DATA_W(DATA_W), .LAT(LAT)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .host                  (host_bus),
      .irq_done              (irq_done),
      .arr_data_clear        (arr_data_clear),
      .arr_en_b_shift_bottom (arr_en_b_shift_bottom),
      .arr_en_shift_right    (arr_en_shift_right),
      .arr_en_shift_bottom   (arr_en_shift_bottom),
      .arr_a_left            (arr_a_left),
      .arr_b_top             (arr_b_top),
      .arr_ps_bottom         (arr_ps_bottom)
   );

   // Behavioural array: weights shift down from the top, A is unskewed from
   // the left edge, bottom sums appear LAT cycles after lane 0's injection.
   logic [N*DATA_W-1:0] wreg [N];
   logic [DATA_W-1:0]   a_seen [N][N];
   int                  stream_t;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream_t <= 0;
      end else begin
         if (arr_en_b_shift_bottom) begin
            wreg[0] <= arr_b_top;
            for (int k = 1; k < int'(N); k++) wreg[k] <= wreg[k-1];
         end
         if (arr_en_shift_right) begin
            for (int i = 0; i < int'(N); i++) begin
               if (stream_t - i >= 0 && stream_t - i < int'(N))
                  a_seen[stream_t - i][i] <= arr_a_left[i*DATA_W +: DATA_W];
            end
            stream_t <= stream_t + 1;
         end else begin
            stream_t <= 0;
         end
      end
   end

   function automatic logic [N*DATA_W-1:0] model_ps(input int t);
      logic [N*DATA_W-1:0] ps;
      logic [DATA_W-1:0]   acc;
      int                  r;
      ps = '0;
      for (int j = 0; j < int'(N); j++) begin
         r = t - j - int'(LAT);
         acc = '0;
         if (r >= 0 && r < int'(N)) begin
            for (int k = 0; k < int'(N); k++)
               acc = acc + DATA_W'(a_seen[r][k] * wreg[k][j*DATA_W +: DATA_W]);
         end
         ps[j*DATA_W +: DATA_W] = acc;
      end
      return ps;
   endfunction

   always @(negedge clk) begin
      arr_ps_bottom <= arr_en_shift_right ? model_ps(stream_t) : '0;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] mk(input logic [1:0] rg, input int idx);
      return {rg, IDX_W'(idx)};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] rg, input int idx, input logic [DATA_W-1:0] d);
      host_bus.we    = 1'b1;
      host_bus.addr  = mk(rg, idx);
      host_bus.wdata = d;
      step();
      host_bus.we    = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [1:0] rg, input int idx,
                           input logic [DATA_W-1:0] exp);
      host_bus.re   = 1'b1;
      host_bus.addr = mk(rg, idx);
      step();
      host_bus.re   = 1'b0;
      check(tag, 64'(host_bus.rdata), 64'(exp));
   endtask

   int   cyc;
   logic irq_seen;

   initial begin
      host_bus.we    = 1'b0;
      host_bus.re    = 1'b0;
      host_bus.addr  = '0;
      host_bus.wdata = '0;

      // Reset state
      @(negedge clk);
      check("rst_ctrl", 64'({irq_done, arr_data_clear, arr_en_b_shift_bottom,
                             arr_en_shift_right, arr_en_shift_bottom, host_bus.rvalid}), 64'd0);
      check("rst_a_left", 64'(arr_a_left), 64'd0);
      check("rst_b_top", 64'(arr_b_top), 64'd0);
      check("rst_rdata", 64'(host_bus.rdata), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      rd_check("status_rst", REG_CSR, CSR_STATUS, 16'd0);
      check("rvalid_pulse_hi", 64'(host_bus.rvalid), 64'd1);
      step();
      check("rvalid_pulse_lo", 64'(host_bus.rvalid), 64'd0);

      // B = identity, A[r][c] = 4r+c+1
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            wr(REG_B, r*4 + c, (r == c) ? 16'd1 : 16'd0);
            wr(REG_A, r*4 + c, 16'(4*r + c + 1));
         end
      end
      rd_check("a_rd_6", REG_A, 6, 16'd7);
      rd_check("b_rd_5", REG_B, 5, 16'd1);

      // Run with a busy-time B write, STATUS read and second start
      wr(REG_CSR, CSR_CTRL, 16'h0001);
      cyc = 1;
      while (irq_done !== 1'b1 && cyc < 100) begin
         if (cyc == 1) check("clear_pulse", 64'(arr_data_clear), 64'd1);
         if (cyc == 2) begin
            check("load_b_en", 64'(arr_en_b_shift_bottom), 64'd1);
            check("b_top_row3", 64'(arr_b_top), 64'h0001_0000_0000_0000);
         end
         if (cyc == 4) check("status_busy_err", 64'({host_bus.rvalid, host_bus.rdata}), 64'h1_0005);
         if (cyc == 6) check("a_left_t0", 64'(arr_a_left), 64'h0000_0000_0000_0001);
         if (cyc == 7) check("a_left_t1", 64'(arr_a_left), 64'h0000_0000_0002_0005);
         host_bus.we = 1'b0;
         host_bus.re = 1'b0;
         if (cyc == 2) begin
            host_bus.we = 1'b1; host_bus.addr = mk(REG_B, 5); host_bus.wdata = 16'h0055;
         end
         if (cyc == 3) begin
            host_bus.re = 1'b1; host_bus.addr = mk(REG_CSR, CSR_STATUS);
         end
         if (cyc == 4) begin
            host_bus.we = 1'b1; host_bus.addr = mk(REG_CSR, CSR_CTRL); host_bus.wdata = 16'h0001;
         end
         step();
         cyc++;
      end
      host_bus.we = 1'b0;
      host_bus.re = 1'b0;
      check("run_len", 64'(cyc), 64'd17);
      step();
      check("irq_pulse_lo", 64'({irq_done, arr_en_shift_right, arr_en_shift_bottom}), 64'd0);
      check("a_left_idle", 64'(arr_a_left), 64'd0);

      rd_check("status_done_err", REG_CSR, CSR_STATUS, 16'd6);
      rd_check("b5_unchanged", REG_B, 5, 16'd1);
      wr(REG_CSR, CSR_CTRL, 16'h0004);
      rd_check("status_err_clr", REG_CSR, CSR_STATUS, 16'd2);

      for (int i = 0; i < 16; i++) rd_check($sformatf("c_%0d", i), REG_C, i, 16'(i + 1));

`ifdef SYS_HOST_CYCLE_CNT_EN
      rd_check("cyc_lo", REG_CSR, CSR_CYC_LO, 16'd17);
`else
      rd_check("cyc_lo", REG_CSR, CSR_CYC_LO, 16'd0);
`endif
      rd_check("cyc_hi", REG_CSR, CSR_CYC_HI, 16'd0);
      rd_check("csr_unmapped", REG_CSR, 5, 16'd0);

      // Writes to C are ignored and flag err
      wr(REG_C, 0, 16'hBEEF);
      rd_check("status_c_wr", REG_CSR, CSR_STATUS, 16'd6);
      rd_check("c0_unchanged", REG_C, 0, 16'd1);

      // Restart after done, then reset mid-STREAM at t=3
      wr(REG_CSR, CSR_CTRL, 16'h0004);
      wr(REG_CSR, CSR_CTRL, 16'h0001);
      rd_check("status_restart", REG_CSR, CSR_STATUS, 16'd1);
      repeat (7) step();
      check("stream_active", 64'(arr_en_shift_right), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", 64'({irq_done, arr_data_clear, arr_en_b_shift_bottom,
                                 arr_en_shift_right, arr_en_shift_bottom}), 64'd0);
      check("rst_mid_a_left", 64'(arr_a_left), 64'd0);
      irq_seen = 1'b0;
      repeat (2) begin
         step();
         irq_seen = irq_seen | irq_done;
      end
      rst_n = 1'b1;
      repeat (20) begin
         step();
         irq_seen = irq_seen | irq_done;
      end
      check("no_irq_after_abort", 64'(irq_seen), 64'd0);
      rd_check("status_after_abort", REG_CSR, CSR_STATUS, 16'd0);
      rd_check("a0_reset", REG_A, 0, 16'd0);
      rd_check("c0_reset", REG_C, 0, 16'd0);

      // Simultaneous write and read returns the old word
      wr(REG_A, 2, 16'd7);
      host_bus.we    = 1'b1;
      host_bus.re    = 1'b1;
      host_bus.addr  = mk(REG_A, 2);
      host_bus.wdata = 16'd9;
      step();
      host_bus.we = 1'b0;
      host_bus.re = 1'b0;
      check("rw_old", 64'({host_bus.rvalid, host_bus.rdata}), 64'h1_0007);
      rd_check("rw_new", REG_A, 2, 16'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
